// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family and its
// reader/writer adapters.
// Contents: state_t (IDLE/SEND) and cnt_w(), the counter-width helper.
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width of a counter that indexes 'ratio' items. It is never zero, so
  // RATIO=1 still yields a legal 1-bit counter.
  function automatic int cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head word
// whenever empty is low.
// Latency: write to empty-low takes 1 cycle. A pop advances the head on the next edge.
// Backpressure: a write while full is dropped and a read while empty is
// ignored. Ports: clk, rst_n (sync, active-low), wr_en/wr_data/full,
// rd_en/rd_data/empty, level (occupancy).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,          // power of two so the pointers wrap naturally
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops DWIDTH-bit words from a FWFT FIFO and emits each one as RATIO
// OWIDTH-bit beats, LSB first, with OUT_LAST on the final beat.
// Latency: first beat is valid 1 cycle after FIFO_EMPTY falls in IDLE, and the next word
// loads on the last-beat handshake without a bubble. Backpressure: while
// OUT_READY is low the beat holds, and no further word is popped.
// Ports: CLK, RST_N (sync, active-low); FIFO_EMPTY/FIFO_RD_EN/FIFO_RD_DATA
// toward the FIFO; OUT_VALID/OUT_READY/OUT_DATA/OUT_LAST toward the
// consumer; BUSY while a word is held. DWIDTH must be a multiple of OWIDTH.
module fifo_rd_serializer
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 8,
  parameter int RATIO  = DWIDTH / OWIDTH,
  parameter int CNT_W  = cnt_w(RATIO)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FIFO_EMPTY,
  output logic              FIFO_RD_EN,
  input  logic [DWIDTH-1:0] FIFO_RD_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [OWIDTH-1:0] OUT_DATA,
  output logic              OUT_LAST,
  output logic              BUSY
);

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [DWIDTH-1:0]  word_q;
  logic               xfer;
  logic               pop;

  // All outputs derive from registered state only. FIFO_RD_EN is the exception:
  // it must react to the handshake in the same cycle to avoid a bubble.
  assign OUT_VALID = (state == SEND);
  assign BUSY      = (state == SEND);
  assign OUT_LAST  = (state == SEND) && (beat_cnt == CNT_W'(RATIO - 1));
  assign OUT_DATA  = word_q[int'(beat_cnt) * OWIDTH +: OWIDTH];

  assign xfer = OUT_VALID && OUT_READY;

  // Gating with RST_N keeps the FIFO from losing a word in a reset cycle,
  // since that pop would never be captured.
  assign pop = RST_N && !FIFO_EMPTY && ((state == IDLE) || (xfer && OUT_LAST));
  assign FIFO_RD_EN = pop;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      beat_cnt <= '0;
      word_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            word_q   <= FIFO_RD_DATA;
            beat_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (OUT_LAST) begin
              beat_cnt <= '0;
              if (pop) begin
                word_q <= FIFO_RD_DATA;   // chain straight into the next word
              end else begin
                state <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench: sync_fifo feeding fifo_rd_serializer at 32->8 (a_*) and 32->32 (b_*).
// Directed scenarios followed by a random push/ready phase checked against
// a queue of expected beats built from the pushed words.
module tb_fifo_rd_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic fifo_rst_n;
  int   checks = 0;
  int   errors = 0;

  // ---- 32 -> 8 path ----
  logic        a_wr_en, a_full, a_empty, a_rd_en;
  logic [31:0] a_wr_data, a_rd_data;
  logic [3:0]  a_level;
  logic        a_valid, a_ready, a_last, a_busy;
  logic [7:0]  a_data;

  // ---- 32 -> 32 path (RATIO=1) ----
  logic        b_wr_en, b_full, b_empty, b_rd_en;
  logic [31:0] b_wr_data, b_rd_data;
  logic [3:0]  b_level;
  logic        b_valid, b_ready, b_last, b_busy;
  logic [31:0] b_data;

  sync_fifo #(.WIDTH(32), .DEPTH(8)) u_fifo_a (
    .clk(clk), .rst_n(fifo_rst_n), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .full(a_full), .rd_en(a_rd_en), .rd_data(a_rd_data), .empty(a_empty),
    .level(a_level));

  fifo_rd_serializer #(.DWIDTH(32), .OWIDTH(8)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .FIFO_EMPTY(a_empty), .FIFO_RD_EN(a_rd_en),
    .FIFO_RD_DATA(a_rd_data), .OUT_VALID(a_valid), .OUT_READY(a_ready),
    .OUT_DATA(a_data), .OUT_LAST(a_last), .BUSY(a_busy));

  sync_fifo #(.WIDTH(32), .DEPTH(8)) u_fifo_b (
    .clk(clk), .rst_n(fifo_rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .full(b_full), .rd_en(b_rd_en), .rd_data(b_rd_data), .empty(b_empty),
    .level(b_level));

  fifo_rd_serializer #(.DWIDTH(32), .OWIDTH(32)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .FIFO_EMPTY(b_empty), .FIFO_RD_EN(b_rd_en),
    .FIFO_RD_DATA(b_rd_data), .OUT_VALID(b_valid), .OUT_READY(b_ready),
    .OUT_DATA(b_data), .OUT_LAST(b_last), .BUSY(b_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input string tag, input logic [7:0] d, input logic l, input logic re);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, a_valid}, 32'd1);
    chk({tag, "_data"},  {24'b0, a_data},  {24'b0, d});
    chk({tag, "_last"},  {31'b0, a_last},  {31'b0, l});
    chk({tag, "_rd_en"}, {31'b0, a_rd_en}, {31'b0, re});
    nxt();
  endtask

  task automatic a_idle(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, a_valid}, 32'd0);
    chk({tag, "_busy"},  {31'b0, a_busy},  32'd0);
    nxt();
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction

  logic [8:0]  exp_q[$];
  logic [8:0]  head;
  logic [31:0] w0, w1, w2, d0, d1, d2;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic        prev_stall;

  initial begin
    rst_n = 1'b0; fifo_rst_n = 1'b0;
    a_wr_en = 1'b0; a_wr_data = '0; a_ready = 1'b0;
    b_wr_en = 1'b0; b_wr_data = '0; b_ready = 1'b0;
    nxt(); nxt();
    fifo_rst_n = 1'b1;
    nxt();

    // Reset state
    @(negedge clk);
    chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_a_last",  {31'b0, a_last},  32'd0);
    chk("rst_a_busy",  {31'b0, a_busy},  32'd0);
    chk("rst_a_rd_en", {31'b0, a_rd_en}, 32'd0);
    chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
    nxt();
    rst_n = 1'b1;

    // 1. Single word
    a_ready = 1'b1; a_wr_en = 1'b1; w0 = 32'h44332211; a_wr_data = w0;
    @(negedge clk);
    chk("t1_rd_en_before", {31'b0, a_rd_en}, 32'd0);
    nxt();
    a_wr_en = 1'b0;
    @(negedge clk);
    chk("t1_pop",       {31'b0, a_rd_en}, 32'd1);
    chk("t1_valid_pop", {31'b0, a_valid}, 32'd0);
    nxt();
    for (int k = 0; k < 4; k++) a_beat("t1", byte_of(w0, k), k == 3, 1'b0);
    a_idle("t1_end");

    // 2. Back-to-back words, no bubble; second pop rides on the DD transfer
    a_ready = 1'b0; a_wr_en = 1'b1;
    w0 = 32'hDDCCBBAA; w1 = 32'h04030201;
    a_wr_data = w0; nxt();
    a_wr_data = w1; nxt();
    a_wr_en = 1'b0; a_ready = 1'b1;
    for (int k = 0; k < 8; k++)
      a_beat("t2", byte_of((k < 4) ? w0 : w1, k % 4), (k % 4) == 3, k == 3);
    a_idle("t2_end");

    // 3. Backpressure on the 0x33 beat
    a_wr_en = 1'b1; w0 = 32'h44332211; a_wr_data = w0; nxt();
    a_wr_en = 1'b0; nxt();
    a_beat("t3_b0", 8'h11, 1'b0, 1'b0);
    a_beat("t3_b1", 8'h22, 1'b0, 1'b0);
    a_ready = 1'b0;
    for (int k = 0; k < 3; k++) a_beat("t3_stall", 8'h33, 1'b0, 1'b0);
    a_ready = 1'b1;
    a_beat("t3_b2", 8'h33, 1'b0, 1'b0);
    a_beat("t3_b3", 8'h44, 1'b1, 1'b0);
    a_idle("t3_end");

    // 4. Empty guard with toggling ready
    for (int k = 0; k < 20; k++) begin
      a_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("t4_rd_en",  {31'b0, a_rd_en}, 32'd0);
      chk("t4_valid",  {31'b0, a_valid}, 32'd0);
      chk("t4_level",  {28'b0, a_level}, 32'd0);
      nxt();
    end

    // 5. Reset after beat 0x22, FIFO still holding the next word
    a_ready = 1'b1; a_wr_en = 1'b1;
    w0 = 32'h44332211; w1 = 32'h88776655;
    a_wr_data = w0; nxt();
    a_wr_data = w1; nxt();
    a_wr_en = 1'b0;
    a_beat("t5_b0", 8'h11, 1'b0, 1'b0);
    a_beat("t5_b1", 8'h22, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rd_en_in_reset", {31'b0, a_rd_en}, 32'd0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid_after", {31'b0, a_valid}, 32'd0);
    chk("t5_busy_after",  {31'b0, a_busy},  32'd0);
    chk("t5_level_kept",  {28'b0, a_level}, 32'd1);
    chk("t5_pop_after",   {31'b0, a_rd_en}, 32'd1);
    nxt();
    for (int k = 0; k < 4; k++) a_beat("t5_w1", byte_of(w1, k), k == 3, 1'b0);
    a_idle("t5_end");

    // 6. RATIO=1 pass-through at full rate
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    b_ready = 1'b1; b_wr_en = 1'b1; b_wr_data = d0; nxt();
    b_wr_data = d1;
    @(negedge clk);
    chk("t6_pop0",   {31'b0, b_rd_en}, 32'd1);
    chk("t6_valid0", {31'b0, b_valid}, 32'd0);
    nxt();
    b_wr_data = d2;
    @(negedge clk);
    chk("t6_data0", b_data, d0);
    chk("t6_last0", {31'b0, b_last},  32'd1);
    chk("t6_pop1",  {31'b0, b_rd_en}, 32'd1);
    nxt();
    b_wr_en = 1'b0;
    @(negedge clk);
    chk("t6_valid1", {31'b0, b_valid}, 32'd1);
    chk("t6_data1",  b_data, d1);
    chk("t6_last1",  {31'b0, b_last},  32'd1);
    chk("t6_pop2",   {31'b0, b_rd_en}, 32'd1);
    nxt();
    @(negedge clk);
    chk("t6_valid2", {31'b0, b_valid}, 32'd1);
    chk("t6_data2",  b_data, d2);
    chk("t6_last2",  {31'b0, b_last},  32'd1);
    chk("t6_pop3",   {31'b0, b_rd_en}, 32'd0);
    nxt();
    @(negedge clk);
    chk("t6_idle", {31'b0, b_valid}, 32'd0);
    nxt();

    // Random traffic: every pushed word becomes four beats, LSB first
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < 400; c++) begin
      a_wr_en   = (a_level < 4'd7) && ($urandom_range(0, 2) == 0);
      a_wr_data = $urandom;
      a_ready   = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (a_empty) chk("rnd_rd_en_empty", {31'b0, a_rd_en}, 32'd0);
      if (prev_stall) begin
        chk("rnd_hold_valid", {31'b0, a_valid}, 32'd1);
        chk("rnd_hold_data",  {24'b0, a_data},  {24'b0, prev_data});
        chk("rnd_hold_last",  {31'b0, a_last},  {31'b0, prev_last});
      end
      if (a_valid && a_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_beat", 32'd1, 32'd0);
        end else begin
          head = exp_q.pop_front();
          chk("rnd_data", {24'b0, a_data}, {24'b0, head[7:0]});
          chk("rnd_last", {31'b0, a_last}, {31'b0, head[8]});
        end
      end
      prev_stall = a_valid && !a_ready;
      prev_data  = a_data;
      prev_last  = a_last;
      if (a_wr_en)
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, byte_of(a_wr_data, k)});
      nxt();
    end
    a_wr_en = 1'b0; a_ready = 1'b1;
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (a_valid) begin
        head = exp_q.pop_front();
        chk("drain_data", {24'b0, a_data}, {24'b0, head[7:0]});
        chk("drain_last", {31'b0, a_last}, {31'b0, head[8]});
      end
      nxt();
    end
    chk("drain_left", exp_q.size(), 32'd0);
    a_idle("drain_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
